// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers (PC, IF/ID, ID/EX) executing hazard-unit stall/bubble/flush commands.
// Optional stall/bubble counters are enabled with `define PIPE_STALL_COUNT_EN.
module pipe_front_regs #(
  parameter int          PC_W      = 16,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter int          CTRL_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       imem_instr,
  input  logic              pcCtrl,
  input  logic              bufferCtrl,
  input  logic              ctrlMux,
  input  logic              opCode_error,
  input  logic [CTRL_W-1:0] dec_ctrl,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   pc,
  output logic [15:0]       IF_ID_instr,
  output logic [PC_W-1:0]   IF_ID_pc4,
  output logic [3:0]        ID_EX_Op1,
  output logic [3:0]        ID_EX_Op2,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic              ID_EX_memRead,
`ifdef PIPE_STALL_COUNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt,
`endif
  output logic              halted
);

  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nxt;

  logic [PC_W-1:0]   pc_nxt, pc4_nxt, pc_inc;
  logic [15:0]       instr_nxt;
  logic [3:0]        op1_nxt, op2_nxt;
  logic [CTRL_W-1:0] ctrl_nxt;

  assign pc_inc        = pc + PC_W'(2);
  assign ID_EX_memRead = ID_EX_ctrl[0];
  assign halted        = (state == HALT);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = IF_ID_instr;
    pc4_nxt   = IF_ID_pc4;
    op1_nxt   = ID_EX_Op1;
    op2_nxt   = ID_EX_Op2;
    ctrl_nxt  = ID_EX_ctrl;
    case (state)
      RUN: begin
        if (branch_taken) begin
          // Flush wins over any stall request and squashes a pending opcode error.
          pc_nxt    = branch_target;
          instr_nxt = NOP_INSTR;
          pc4_nxt   = '0;
          op1_nxt   = '0;
          op2_nxt   = '0;
          ctrl_nxt  = '0;
        end else if (opCode_error) begin
          state_nxt = HALT;
          ctrl_nxt  = '0;
        end else begin
          if (pcCtrl) pc_nxt = pc_inc;
          if (bufferCtrl) begin
            instr_nxt = imem_instr;
            pc4_nxt   = pc_inc;
          end
          op1_nxt  = IF_ID_instr[11:8];
          op2_nxt  = IF_ID_instr[7:4];
          ctrl_nxt = ctrlMux ? '0 : dec_ctrl;
        end
      end
      HALT:    ctrl_nxt = '0;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= '0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_pc4   <= '0;
      ID_EX_Op1   <= '0;
      ID_EX_Op2   <= '0;
      ID_EX_ctrl  <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      IF_ID_instr <= instr_nxt;
      IF_ID_pc4   <= pc4_nxt;
      ID_EX_Op1   <= op1_nxt;
      ID_EX_Op2   <= op2_nxt;
      ID_EX_ctrl  <= ctrl_nxt;
    end
  end

`ifdef PIPE_STALL_COUNT_EN
  // Counters sample the command inputs of every RUN cycle and saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (state == RUN) begin
      if (!pcCtrl && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if ((ctrlMux || branch_taken) && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed bench for pipe_front_regs: per-cycle comparison against a behavioural model plus literal checks.
module tb_pipe_front_regs;
  localparam int PC_W = 16;
  localparam int CTRL_W = 8;
  localparam logic [15:0] NOP = 16'h0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       imem_instr;
  logic              pcCtrl, bufferCtrl, ctrlMux, opCode_error, branch_taken;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [PC_W-1:0]   branch_target;
  logic [PC_W-1:0]   pc, IF_ID_pc4;
  logic [15:0]       IF_ID_instr;
  logic [3:0]        ID_EX_Op1, ID_EX_Op2;
  logic [CTRL_W-1:0] ID_EX_ctrl;
  logic              ID_EX_memRead, halted;
`ifdef PIPE_STALL_COUNT_EN
  logic [15:0]       stall_cnt, bubble_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  int unsigned m_pc, m_pc4, m_instr, m_op1, m_op2, m_ctrl, m_stall, m_bubble;
  bit m_halt;

  pipe_front_regs #(.PC_W(PC_W), .NOP_INSTR(NOP), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .imem_instr(imem_instr), .pcCtrl(pcCtrl),
    .bufferCtrl(bufferCtrl), .ctrlMux(ctrlMux), .opCode_error(opCode_error),
    .dec_ctrl(dec_ctrl), .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .IF_ID_instr(IF_ID_instr), .IF_ID_pc4(IF_ID_pc4),
    .ID_EX_Op1(ID_EX_Op1), .ID_EX_Op2(ID_EX_Op2), .ID_EX_ctrl(ID_EX_ctrl),
    .ID_EX_memRead(ID_EX_memRead),
`ifdef PIPE_STALL_COUNT_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by the rules of one clock edge, using the inputs currently applied.
  task automatic model_edge();
    if (rst) begin
      m_pc = 0; m_pc4 = 0; m_instr = NOP; m_op1 = 0; m_op2 = 0; m_ctrl = 0;
      m_halt = 0; m_stall = 0; m_bubble = 0;
      return;
    end
    if (m_halt) return;
    if (!pcCtrl && m_stall < 16'hFFFF) m_stall++;
    if ((ctrlMux || branch_taken) && m_bubble < 16'hFFFF) m_bubble++;
    if (branch_taken) begin
      m_pc = branch_target; m_instr = NOP; m_pc4 = 0; m_op1 = 0; m_op2 = 0; m_ctrl = 0;
    end else if (opCode_error) begin
      m_halt = 1; m_ctrl = 0;
    end else begin
      int unsigned nxt;
      nxt = (m_pc + 2) % (1 << PC_W);
      m_op1 = (m_instr >> 8) & 4'hF;
      m_op2 = (m_instr >> 4) & 4'hF;
      if (bufferCtrl) begin m_instr = imem_instr; m_pc4 = nxt; end
      if (pcCtrl) m_pc = nxt;
      m_ctrl = ctrlMux ? 0 : dec_ctrl;
    end
  endtask

  task automatic compare_all();
    chk("pc", 32'(pc), m_pc);
    chk("IF_ID_instr", 32'(IF_ID_instr), m_instr);
    chk("IF_ID_pc4", 32'(IF_ID_pc4), m_pc4);
    chk("ID_EX_Op1", 32'(ID_EX_Op1), m_op1);
    chk("ID_EX_Op2", 32'(ID_EX_Op2), m_op2);
    chk("ID_EX_ctrl", 32'(ID_EX_ctrl), m_ctrl);
    chk("ID_EX_memRead", 32'(ID_EX_memRead), m_ctrl & 1);
    chk("halted", 32'(halted), 32'(m_halt));
`ifdef PIPE_STALL_COUNT_EN
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    chk("bubble_cnt", 32'(bubble_cnt), m_bubble);
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input logic pc_e, input logic buf_e, input logic bub,
                       input logic br, input logic [PC_W-1:0] tgt, input logic err);
    pcCtrl = pc_e; bufferCtrl = buf_e; ctrlMux = bub;
    branch_taken = br; branch_target = tgt; opCode_error = err;
  endtask

  initial begin
    // Reset with random command inputs
    rst = 1'b1;
    imem_instr = 16'($urandom); dec_ctrl = 8'($urandom);
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
    @(negedge clk);
    tick();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
    tick();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_instr", 32'(IF_ID_instr), 32'(NOP));
    chk("rst_ctrl", 32'(ID_EX_ctrl), 0);
    chk("rst_halted", 32'(halted), 0);

    // Free run
    rst = 1'b0;
    imem_instr = 16'h1230; dec_ctrl = 8'hA5;
    drive(1, 1, 0, 0, '0, 0);
    tick();
    chk("run_pc1", 32'(pc), 2);
    tick();
    chk("run_pc2", 32'(pc), 4);
    chk("run_op1", 32'(ID_EX_Op1), 2);
    chk("run_op2", 32'(ID_EX_Op2), 3);
    chk("run_ctrl", 32'(ID_EX_ctrl), 32'h A5);
    tick();
    chk("run_pc3", 32'(pc), 6);
    chk("run_memRead", 32'(ID_EX_memRead), 1);

    // Load-use stall at pc=6
    imem_instr = 16'h4560;
    drive(0, 0, 1, 0, '0, 0);
    tick();
    chk("stall_pc", 32'(pc), 6);
    chk("stall_instr_held", 32'(IF_ID_instr), 32'h1230);
    chk("stall_ctrl", 32'(ID_EX_ctrl), 0);
    chk("stall_memRead", 32'(ID_EX_memRead), 0);
    drive(1, 1, 0, 0, '0, 0);
    tick();
    chk("after_stall_pc", 32'(pc), 8);
    chk("after_stall_instr", 32'(IF_ID_instr), 32'h4560);

    // Inconsistent enables: PC moves, IF/ID holds
    imem_instr = 16'h7890; dec_ctrl = 8'h3C;
    drive(1, 0, 0, 0, '0, 0);
    tick();
    chk("split_pc", 32'(pc), 10);
    chk("split_instr", 32'(IF_ID_instr), 32'h4560);
    drive(1, 1, 0, 0, '0, 0);
    tick();

    // Branch overrides stall
    drive(0, 0, 1, 1, 16'h0040, 0);
    tick();
    chk("br_pc", 32'(pc), 32'h40);
    chk("br_instr", 32'(IF_ID_instr), 32'(NOP));
    chk("br_ctrl", 32'(ID_EX_ctrl), 0);

    // Branch squashes an opcode error
    drive(1, 1, 0, 1, 16'h0010, 1);
    tick();
    chk("squash_halted", 32'(halted), 0);
    chk("squash_pc", 32'(pc), 32'h10);

    // Illegal opcode at pc=0x10
    dec_ctrl = 8'hFF;
    drive(1, 1, 0, 0, '0, 1);
    tick();
    chk("err_halted", 32'(halted), 1);
    chk("err_ctrl", 32'(ID_EX_ctrl), 0);
    drive(1, 1, 0, 1, 16'h0080, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_pc", 32'(pc), 32'h10);
    end
    chk("halt_ctrl", 32'(ID_EX_ctrl), 0);
    rst = 1'b1;
    tick();
    chk("rst_from_halt_pc", 32'(pc), 0);
    chk("rst_from_halt_halted", 32'(halted), 0);
    rst = 1'b0;

    // Counters: 3 stall cycles with bubbles
    drive(0, 0, 1, 0, '0, 0);
    repeat (3) tick();
`ifdef PIPE_STALL_COUNT_EN
    chk("stall_cnt_3", 32'(stall_cnt), 3);
    chk("bubble_cnt_3", 32'(bubble_cnt), 3);
`endif
    chk("stall3_pc", 32'(pc), 0);

    // PC wrap
    drive(1, 1, 0, 1, 16'hFFFC, 0);
    tick();
    drive(1, 1, 0, 0, '0, 0);
    tick();
    chk("wrap_pc_max", 32'(pc), 32'hFFFE);
    tick();
    chk("wrap_pc0", 32'(pc), 0);
    chk("wrap_pc4", 32'(IF_ID_pc4), 0);
    tick();
    chk("wrap_pc2", 32'(pc), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
